imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 6, meaning the width of the opaque tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered entries.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_instr  input  32, in_tag  input  TAG_W: the upstream handshake, instruction word and tag.
REQ-007 SHALL have ports out_valid  output  1, out_ready  input  1, out_imm  output  XLEN, out_fmt  output  3, out_tag  output  TAG_W: the downstream handshake, immediate, format code and tag.

Function
REQ-008 SHALL decode by opcode in_instr[6:0]: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; all others -> NONE.
REQ-009 SHALL encode out_fmt as NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6; code 7 SHALL never be driven.
REQ-010 SHALL form I = sext(instr[31:20]), S = sext({instr[31:25],instr[11:7]}), B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}), U = sext({instr[31:12],12'b0}), J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}), with sign extension to XLEN from the top bit of each field.
REQ-011 SHALL drive out_imm = 0 for format NONE.
REQ-012 SHALL transfer an input when in_valid && in_ready and an output when out_valid && out_ready.
REQ-013 SHALL have latency of exactly 1 cycle: an input accepted at edge N SHALL be presented at out_* after edge N when the output stage is empty or draining.
REQ-014 SHALL implement a 2-entry buffer: one output register plus one skid register.
REQ-015 SHALL drive in_ready = !skid_valid, as a registered value with no combinational path from out_ready.
REQ-016 SHALL, when the output register is empty or draining, load it from the skid entry if that entry is valid, otherwise from the accepted input, otherwise leave it empty.
REQ-017 SHALL, when the output register is occupied and not draining and an input is accepted, store the decoded input into the skid register.
REQ-018 SHALL preserve strict in-order delivery; entries SHALL never be dropped or duplicated except on flush or reset.
REQ-019 SHALL hold out_imm, out_fmt and out_tag stable while out_valid && !out_ready.
REQ-020 SHALL, when flush is asserted, invalidate both entries at the next edge and ignore any input handshake in that cycle; in_ready SHALL be 1 the following cycle.
REQ-021 SHALL give flush and reset priority over all handshake activity in the same cycle.

Reset
REQ-022 SHALL, on reset, clear out_valid to 0 and skid_valid to 0 and drive in_ready to 1, out_imm to 0, out_fmt to 0 and out_tag to 0.
REQ-023 SHALL, when reset is asserted mid-stream, discard any entry held in either the output or skid register.

Configuration
REQ-024 SHALL support macro IMM_GEN_CSR_ZIMM_EN: when defined, opcode 1110011 with instr[14]=1 SHALL give fmt Z and out_imm = zext(instr[19:15]); when undefined, that opcode SHALL give fmt NONE and out_imm 0.

Verification
REQ-025 SHALL pass this test: instr 0xFFF00093, tag 3, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_fmt=1, out_tag=3.
REQ-026 SHALL pass this test: back-to-back instrs 0x123450B7, 0xFFDFF06F, 0xFE001CE3, 0x0020A423 -> outputs 0x12345000/4, 0xFFFFFFFC/5, 0xFFFFFFF8/3, 0x00000008/2, one per cycle in order.
REQ-027 SHALL pass this test: with out_ready=0, three valid inputs offered -> first two accepted, in_ready=0 on the third; raising out_ready drains all three in order with no loss.
REQ-028 SHALL pass this test: with both entries full, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle input never appears at the output.
REQ-029 SHALL pass this test: instr 0x3002D073 -> with IMM_GEN_CSR_ZIMM_EN, out_imm=5 and out_fmt=6; without it, out_imm=0 and out_fmt=0.
REQ-030 SHALL pass this test: XLEN=64 with instr 0xFFDFF06F -> out_imm=0xFFFFFFFFFFFFFFFC.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder behind a 2-entry output/skid buffer
// Optional CSR zimm decode enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    logic [31:0]      dec_imm32;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             accept;

    // Every field is first sign-extended to 32 bits, then widened to XLEN.
    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_NONE;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
`ifdef IMM_GEN_CSR_ZIMM_EN
            7'b1110011: begin
                if (in_instr[14]) begin
                    dec_fmt   = FMT_Z;
                    dec_imm32 = {27'd0, in_instr[19:15]};
                end
            end
`endif
            default: begin
                dec_fmt   = FMT_NONE;
                dec_imm32 = 32'd0;
            end
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_tag_d   = skid_tag_q;
        accept       = in_valid && !skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Skid entry is older than anything arriving now, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and random checks of imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [5:0]  in_tag;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_imm;
    logic [63:0] b_out_imm;
    logic [2:0]  a_out_fmt, b_out_fmt;
    logic [5:0]  a_out_tag, b_out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [5:0]  tag;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(6)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(6)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_tag(b_out_tag)
    );

    function automatic logic [2:0] ref_fmt(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
            7'h73:               return i[14] ? 3'd6 : 3'd0;
`endif
            default:             return 3'd0;
        endcase
    endfunction

    // Arithmetic view: shift the signed word to pick up the sign, OR in the scattered fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f);
        longint si;
        si = longint'($signed(i));
        case (f)
            3'd1: return 64'(si >>> 20);
            3'd2: return 64'(((si >>> 25) << 5) | longint'(i[11:7]));
            3'd3: return 64'(((si >>> 31) << 12) | (longint'(i[7]) << 11)
                             | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1));
            3'd4: return 64'((si >>> 12) << 12);
            3'd5: return 64'(((si >>> 31) << 20) | (longint'(i[19:12]) << 12)
                             | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1));
            3'd6: return 64'(longint'(i[19:15]));
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid32", {63'd0, a_out_valid}, {63'd0, q.size() > 0});
        chk("in_ready32",  {63'd0, a_in_ready},  {63'd0, q.size() < 2});
        chk("out_valid64", {63'd0, b_out_valid}, {63'd0, q.size() > 0});
        chk("in_ready64",  {63'd0, b_in_ready},  {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("imm32", {32'd0, a_out_imm}, {32'd0, q[0].imm[31:0]});
            chk("fmt32", {61'd0, a_out_fmt}, {61'd0, q[0].fmt});
            chk("tag32", {58'd0, a_out_tag}, {58'd0, q[0].tag});
            chk("imm64", b_out_imm, q[0].imm);
            chk("fmt64", {61'd0, b_out_fmt}, {61'd0, q[0].fmt});
        end
    endtask

    // Drive one cycle, advance the queue model at the edge, check at the falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [5:0] tg,
                        input logic ordy, input logic fl, input logic rs);
        logic acc, drn;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        acc   = v && (q.size() < 2);
        drn   = (q.size() > 0) && ordy;
        e.fmt = ref_fmt(ins);
        e.imm = ref_imm(ins, e.fmt);
        e.tag = tg;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        logic [31:0] ins26 [4];
        logic [31:0] exp26 [4];
        logic [2:0]  fmt26 [4];
        logic [6:0]  ops [10];
        logic [31:0] r;
        ins26 = '{32'h123450B7, 32'hFFDFF06F, 32'hFE001CE3, 32'h0020A423};
        exp26 = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000008};
        fmt26 = '{3'd4, 3'd5, 3'd3, 3'd2};
        ops   = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_tag = 6'd0;
        @(negedge clk);
        step(1'b1, 32'hFFF00093, 6'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, a_in_ready},  64'd1);
        chk("rst_imm", {32'd0, a_out_imm}, 64'd0);
        chk("rst_fmt", {61'd0, a_out_fmt}, 64'd0);
        chk("rst_tag", {58'd0, a_out_tag}, 64'd0);

        step(1'b1, 32'hFFF00093, 6'd3, 1'b1, 1'b0, 1'b0);
        chk("addi_imm", {32'd0, a_out_imm}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'd0, a_out_fmt}, 64'd1);
        chk("addi_tag", {58'd0, a_out_tag}, 64'd3);

        for (int k = 0; k < 4; k++) begin
            step(1'b1, ins26[k], 6'(k), 1'b1, 1'b0, 1'b0);
            chk("b2b_imm", {32'd0, a_out_imm}, {32'd0, exp26[k]});
            chk("b2b_fmt", {61'd0, a_out_fmt}, {61'd0, fmt26[k]});
        end
        step(1'b0, 32'd0, 6'd0, 1'b1, 1'b0, 1'b0);

        step(1'b1, 32'h00500093, 6'd10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00600093, 6'd11, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", {63'd0, a_in_ready}, 64'd0);
        step(1'b1, 32'h00700093, 6'd12, 1'b0, 1'b0, 1'b0);
        chk("stall_tag_hold", {58'd0, a_out_tag}, 64'd10);
        step(1'b1, 32'h00700093, 6'd12, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h00700093, 6'd12, 1'b1, 1'b0, 1'b0);
        chk("drain_tag12", {58'd0, a_out_tag}, 64'd12);
        step(1'b0, 32'd0, 6'd0, 1'b1, 1'b0, 1'b0);

        step(1'b1, 32'h00100093, 6'd20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 6'd21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 6'd22, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, a_in_ready},  64'd1);
        step(1'b0, 32'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("flush_no_ghost", {63'd0, a_out_valid}, 64'd0);

        step(1'b1, 32'h3002D073, 6'd30, 1'b1, 1'b0, 1'b0);
`ifdef IMM_GEN_CSR_ZIMM_EN
        chk("zimm_imm", {32'd0, a_out_imm}, 64'd5);
        chk("zimm_fmt", {61'd0, a_out_fmt}, 64'd6);
`else
        chk("zimm_imm", {32'd0, a_out_imm}, 64'd0);
        chk("zimm_fmt", {61'd0, a_out_fmt}, 64'd0);
`endif
        step(1'b1, 32'hFFDFF06F, 6'd31, 1'b1, 1'b0, 1'b0);
        chk("jal_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFFC);

        for (int n = 0; n < 500; n++) begin
            r = $urandom();
            step($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 9)]},
                 6'($urandom()), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
